// File: rtl/uart_tx_queue.sv
// uart_tx_queue
// -------------
// Byte FIFO plus a drain state machine that feeds a UART transmitter through
// its enable/busy handshake. Producers push at any rate; the queue hands the
// bytes out one at a time and exposes full/empty/level/overflow for status.
//
// Optional feature macro: UART_TXQ_FLUSH_EN (adds the flush input).
//
// Ports:
//   clk        system clock
//   resetn     asynchronous assertion, active-low reset
//   wr_en      push wr_data this cycle
//   wr_data    byte to queue
//   full       level == DEPTH
//   empty      level == 0
//   level      entries currently stored (AW+1 bits)
//   overflow   sticky, set when a push is dropped because the queue is full
//   ovf_clr    clears overflow (a simultaneous set wins)
//   tx_en      one-cycle registered request to the transmitter
//   tx_data    registered byte presented with tx_en, held until next issue
//   tx_busy    transmitter busy indication
//   idle       queue empty, FSM idle, tx_busy low and tx_en low
//   flush      (UART_TXQ_FLUSH_EN only) discard all queued bytes
//   fsm_state  drain FSM state for observation (0 IDLE, 1 ACK, 2 DONE)
//
// Handshake: the FSM issues only from IDLE while tx_busy is low; tx_en is
// high for exactly one cycle per popped byte. It then waits in ACK for
// tx_busy to rise and in DONE for tx_busy to fall before issuing again.
// There is no ACK timeout: the transmitter always answers tx_en.

module uart_tx_queue #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow,
  input  logic          ovf_clr,
  output logic          tx_en,
  output logic [7:0]    tx_data,
  input  logic          tx_busy,
  output logic          idle,
`ifdef UART_TXQ_FLUSH_EN
  input  logic          flush,
`endif
  output logic [1:0]    fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ACK  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  state_t        state_q, state_d;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   level_q;
  logic          ovf_q;
  logic          tx_en_q;
  logic [7:0]    tx_data_q;
  logic          flush_i;
  logic          push;
  logic          issue;
  logic          ovf_set;

`ifdef UART_TXQ_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // Status is decoded from the level register only, so there is no
  // combinational path from wr_en to full/empty/level/idle.
  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);
  assign level = level_q;

  // A pop in the same cycle never makes room for a push while full; flush
  // takes priority over a push and does not count as an overflow.
  assign push    = wr_en && !full && !flush_i;
  assign ovf_set = wr_en && full && !flush_i;

  // Drain FSM: next state and issue decision.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty && !tx_busy && !flush_i) begin
          issue   = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (tx_busy) state_d = S_DONE;
      end
      S_DONE: begin
        if (!tx_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
      tx_en_q   <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      state_q <= state_d;
      tx_en_q <= issue;
      if (issue) tx_data_q <= mem[rd_ptr];

      if (flush_i) begin
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        level_q <= '0;
      end else begin
        if (push)  wr_ptr <= wr_ptr + 1'b1;
        if (issue) rd_ptr <= rd_ptr + 1'b1;
        case ({push, issue})
          2'b10:   level_q <= level_q + 1'b1;
          2'b01:   level_q <= level_q - 1'b1;
          default: level_q <= level_q;
        endcase
      end

      if (ovf_set)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  // Storage is intentionally not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign overflow  = ovf_q;
  assign tx_en     = tx_en_q;
  assign tx_data   = tx_data_q;
  assign idle      = empty && (state_q == S_IDLE) && !tx_busy && !tx_en_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: directed stimulus, a transmitter model that answers
// tx_en with a fixed-length busy frame, and a monitor that pops the expected
// byte queue on every tx_en pulse. Inputs are driven and outputs sampled on
// the falling clock edge.

module tb_uart_tx_queue;

  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int FRAME = 6;

  logic          clk;
  logic          resetn;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          overflow;
  logic          ovf_clr;
  logic          tx_en;
  logic [7:0]    tx_data;
  logic          tx_busy;
  logic          idle;
  logic [1:0]    fsm_state;
`ifdef UART_TXQ_FLUSH_EN
  logic          flush;
`endif

  logic          hold_busy;
  logic          model_busy;
  assign tx_busy = hold_busy | model_busy;

  int compared   = 0;
  int mismatched = 0;
  int n_pulse    = 0;
  int cyc        = 0;
  logic [7:0] exp_q[$];

  uart_tx_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .tx_en     (tx_en),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .idle      (idle),
`ifdef UART_TXQ_FLUSH_EN
    .flush     (flush),
`endif
    .fsm_state (fsm_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor + transmitter model ----------------
  initial begin
    logic       prev_tx_en;
    logic       gap_ref_valid;
    int         last_busy_hi;
    int         cnt;
    logic [7:0] e;
    prev_tx_en    = 1'b0;
    gap_ref_valid = 1'b0;
    last_busy_hi  = 0;
    cnt           = 0;
    model_busy    = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (tx_en) begin
        n_pulse++;
        check("tx_en_single_cycle", {31'd0, prev_tx_en}, 32'd0);
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_tx_en: tx_data %0h with no byte expected", tx_data);
        end else begin
          e = exp_q.pop_front();
          check("tx_data_order", {24'd0, tx_data}, {24'd0, e});
        end
        if (gap_ref_valid) begin
          check("issue_gap_ge3", {31'd0, (cyc - last_busy_hi) >= 3}, 32'd1);
          gap_ref_valid = 1'b0;
        end
      end
      prev_tx_en = tx_en;
      if (hold_busy) gap_ref_valid = 1'b0;
      // transmitter: busy for FRAME samples after seeing tx_en
      if (!resetn) begin
        model_busy    = 1'b0;
        cnt           = 0;
        gap_ref_valid = 1'b0;
      end else if (model_busy) begin
        cnt++;
        if (cnt == FRAME) begin
          model_busy    = 1'b0;
          last_busy_hi  = cyc - 1;
          gap_ref_valid = !hold_busy;
        end
      end else if (tx_en) begin
        model_busy = 1'b1;
        cnt        = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (!idle && n < budget) begin
      tick();
      n++;
    end
    check({name, "_idle"}, {31'd0, idle}, 32'd1);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (fsm_state != 2'd2 && n < budget) begin
      tick();
      n++;
    end
    check({name, "_in_done"}, {30'd0, fsm_state}, 32'd2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p0;
    resetn    = 1'b0;
    wr_en     = 1'b0;
    wr_data   = 8'h00;
    ovf_clr   = 1'b0;
    hold_busy = 1'b0;
`ifdef UART_TXQ_FLUSH_EN
    flush     = 1'b0;
`endif
    repeat (3) tick();

    // reset state
    check("rst_full",     {31'd0, full},     32'd0);
    check("rst_empty",    {31'd0, empty},    32'd1);
    check("rst_level",    {28'd0, level},    32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_tx_en",    {31'd0, tx_en},    32'd0);
    check("rst_tx_data",  {24'd0, tx_data},  32'd0);
    check("rst_idle",     {31'd0, idle},     32'd1);
    check("rst_state",    {30'd0, fsm_state}, 32'd0);
    resetn = 1'b1;
    tick();

    // single byte latency
    wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
    tick();
    wr_en = 1'b0;
    check("one_level_after_push", {28'd0, level}, 32'd1);
    check("one_empty_after_push", {31'd0, empty}, 32'd0);
    check("one_tx_en_not_yet",    {31'd0, tx_en}, 32'd0);
    tick();
    check("one_tx_en",      {31'd0, tx_en},   32'd1);
    check("one_tx_data",    {24'd0, tx_data}, 32'h0000_00A5);
    check("one_level_zero", {28'd0, level},   32'd0);
    check("one_empty",      {31'd0, empty},   32'd1);
    wait_idle("one", 100);

    // fill to full while transmitter busy
    hold_busy = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; wr_data = 8'(i); exp_q.push_back(8'(i));
      tick();
    end
    wr_en = 1'b0;
    check("fill_full",  {31'd0, full},  32'd1);
    check("fill_level", {28'd0, level}, 32'd8);
    check("fill_no_tx", n_pulse, 1);

    // overflow behaviour
    wr_en = 1'b1; wr_data = 8'hFF;
    tick();
    wr_en = 1'b0;
    check("ovf_set",   {31'd0, overflow}, 32'd1);
    check("ovf_level", {28'd0, level},    32'd8);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clear", {31'd0, overflow}, 32'd0);
    wr_en = 1'b1; wr_data = 8'hFF; ovf_clr = 1'b1;
    tick();
    wr_en = 1'b0; ovf_clr = 1'b0;
    check("ovf_set_wins", {31'd0, overflow}, 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clear2", {31'd0, overflow}, 32'd0);

    // drain 01..08
    hold_busy = 1'b0;
    wait_idle("drain8", 300);
    check("drain8_exp_empty", exp_q.size(), 0);
    check("drain8_pulses",    n_pulse, 9);

    // push and pop in the same cycle at level 3
    hold_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'h10 + 8'(i); exp_q.push_back(8'h10 + 8'(i));
      tick();
    end
    wr_en = 1'b0;
    check("pp_level_before", {28'd0, level}, 32'd3);
    hold_busy = 1'b0;
    wr_en = 1'b1; wr_data = 8'h13; exp_q.push_back(8'h13);
    tick();
    wr_en = 1'b0;
    check("pp_level_same", {28'd0, level}, 32'd3);
    check("pp_tx_en",      {31'd0, tx_en}, 32'd1);
    wait_idle("pp", 200);

    // wrap: 20 bytes through the queue without overflow
    for (int i = 0; i < 20; i++) begin
      int n;
      n = 0;
      while (full && n < 100) begin
        tick();
        n++;
      end
      wr_en = 1'b1; wr_data = 8'h40 + 8'(i); exp_q.push_back(8'h40 + 8'(i));
      tick();
      wr_en = 1'b0;
    end
    wait_idle("wrap", 600);
    check("wrap_exp_empty", exp_q.size(), 0);
    check("wrap_no_ovf",    {31'd0, overflow}, 32'd0);

    // asynchronous reset while in DONE with 4 queued
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'h80 + 8'(i); exp_q.push_back(8'h80 + 8'(i));
      tick();
    end
    wr_en = 1'b0;
    wait_done("rstmid", 50);
    check("rstmid_level_before", {28'd0, level}, 32'd4);
    #2;
    resetn = 1'b0;
    exp_q.delete();
    #1;
    check("rstmid_tx_en",   {31'd0, tx_en},   32'd0);
    check("rstmid_empty",   {31'd0, empty},   32'd1);
    check("rstmid_level",   {28'd0, level},   32'd0);
    check("rstmid_tx_data", {24'd0, tx_data}, 32'd0);
    check("rstmid_state",   {30'd0, fsm_state}, 32'd0);
    repeat (2) tick();
    resetn = 1'b1;
    p0 = n_pulse;
    repeat (20) tick();
    check("rstmid_no_tx_after", n_pulse, p0);
    check("rstmid_idle",        {31'd0, idle}, 32'd1);

`ifdef UART_TXQ_FLUSH_EN
    // flush with level 5 and a byte in flight
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'hC0 + 8'(i); exp_q.push_back(8'hC0 + 8'(i));
      tick();
    end
    wr_en = 1'b0;
    wait_done("flush", 50);
    check("flush_level_before", {28'd0, level}, 32'd5);
    flush = 1'b1;
    exp_q.delete();
    p0 = n_pulse;
    tick();
    flush = 1'b0;
    check("flush_level", {28'd0, level}, 32'd0);
    check("flush_empty", {31'd0, empty}, 32'd1);
    wait_idle("flush", 100);
    repeat (10) tick();
    check("flush_no_more_tx", n_pulse, p0);
    check("flush_no_ovf",     {31'd0, overflow}, 32'd0);
`endif

    repeat (5) tick();
    check("final_exp_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
